uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART receiver, in the same 16x-oversampled clk_rx domain. It captures each completed frame's data byte together with its 3-bit error word {PAR_ERR, FRAME_ERR, DO_ERR}. It queues the pair for the host, which drains it with a registered read handshake. It is the point in the UART where data-overrun (DO) is detected and reported.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo_mem.sv | 45 ++++
 rtl/uart_rx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: error-word layout, default widths and the
// parity/stop encodings used by the receiver, transmitter and RX FIFO.
package uart_pkg;

  // Error word layout, {PAR, FRAME, DO}
  localparam int unsigned ERR_DO    = 0;
  localparam int unsigned ERR_FRAME = 1;
  localparam int unsigned ERR_PAR   = 2;

  localparam int unsigned UART_EW = 3;
  localparam int unsigned UART_DW = 8;

  typedef enum logic [1:0] {
    ParNone = 2'b00,
    ParEven = 2'b01,
    ParOdd  = 2'b10
  } parity_e;

  typedef enum logic {
    Stop1 = 1'b0,
    Stop2 = 1'b1
  } stop_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART RX FIFO.
// Ports:
//   clk_rx      - sole clock
//   reset       - async active-high reset (read register only, array is not reset)
//   we/waddr/wdata - synchronous write port
//   re/raddr    - read request; rdata loads on the next edge and holds otherwise
//   rdata       - registered read data
module uart_fifo_mem #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 11
) (
  input  logic          clk_rx,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int unsigned Depth = 2 ** AW;

  logic [W-1:0] mem_q [Depth];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_rx) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read uses the pre-edge contents, so a same-address write/read (full FIFO)
  // returns the old entry.
  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: queues {data, error word} pairs from the receiver for the
// host, with a 1-cycle registered read, and detects/reports data overrun.
// Ports:
//   clk_rx, reset         - clock, async active-high reset
//   wr_en, din, err_in    - one write strobe per received frame
//   rd_en                 - host read request
//   ovr_clr               - clears the sticky overrun flag
//   dout, err_out         - read data and its error word (hold between reads)
//   dout_valid            - one-cycle strobe when dout/err_out are updated
//   empty, full, count    - occupancy status
//   overrun               - sticky, set when a write is dropped
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DW = UART_DW,
  parameter int unsigned AW = 4,
  parameter int unsigned EW = UART_EW
) (
  input  logic          clk_rx,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic [EW-1:0] err_in,
  input  logic          rd_en,
  input  logic          ovr_clr,
  output logic [DW-1:0] dout,
  output logic [EW-1:0] err_out,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun
);

  localparam int unsigned Depth = 2 ** AW;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q;
  logic          overrun_q, overrun_d;
  logic          pend_do_q, pend_do_d;
  logic          dout_valid_q;

  logic          wr_acc, wr_drop, rd_acc;
  logic [EW-1:0] err_store;
  logic [DW+EW-1:0] rdata;

  // A read frees the slot of a full FIFO in the same cycle; a write into an
  // empty FIFO cannot be read back until it is stored.
  assign wr_acc  = wr_en & (~full_q | rd_en);
  assign wr_drop = wr_en & full_q & ~rd_en;
  assign rd_acc  = rd_en & ~empty_q;

  always_comb begin
    err_store         = err_in;
    err_store[ERR_DO] = err_in[ERR_DO] | pend_do_q;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pend_do_d = pend_do_q;
    overrun_d = overrun_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // The entry after a drop carries DO so the host learns where data was lost.
    if (wr_acc) begin
      pend_do_d = 1'b0;
    end else if (wr_drop) begin
      pend_do_d = 1'b1;
    end

    // A drop in the same cycle as ovr_clr keeps the flag set.
    if (wr_drop) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      pend_do_q    <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= (count_d == '0);
      full_q       <= (count_d == (AW+1)'(Depth));
      overrun_q    <= overrun_d;
      pend_do_q    <= pend_do_d;
      dout_valid_q <= rd_acc;
    end
  end

  uart_fifo_mem #(
    .AW (AW),
    .W  (DW + EW)
  ) u_mem (
    .clk_rx (clk_rx),
    .reset  (reset),
    .we     (wr_acc),
    .waddr  (wr_ptr_q),
    .wdata  ({din, err_store}),
    .re     (rd_acc),
    .raddr  (rd_ptr_q),
    .rdata  (rdata)
  );

  assign dout       = rdata[DW+EW-1:EW];
  assign err_out    = rdata[EW-1:0];
  assign dout_valid = dout_valid_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign count      = count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int EW    = 3;
  localparam int DEPTH = 16;

  logic          clk_rx = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] din;
  logic [EW-1:0] err_in;
  logic          rd_en;
  logic          ovr_clr;
  logic [DW-1:0] dout;
  logic [EW-1:0] err_out;
  logic          dout_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;

  int checks   = 0;
  int failures = 0;
  int valid_pulses = 0;

  // Reference model: a queue of {byte, error word} entries plus flags.
  logic [DW+EW-1:0] m_q[$];
  logic             m_pend;
  logic             m_ovr;
  logic [DW-1:0]    m_dout;
  logic [EW-1:0]    m_err;
  logic             m_valid;

  uart_rx_fifo dut (
    .clk_rx     (clk_rx),
    .reset      (reset),
    .wr_en      (wr_en),
    .din        (din),
    .err_in     (err_in),
    .rd_en      (rd_en),
    .ovr_clr    (ovr_clr),
    .dout       (dout),
    .err_out    (err_out),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun)
  );

  always #5 clk_rx = ~clk_rx;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend  = 1'b0;
    m_ovr   = 1'b0;
    m_dout  = '0;
    m_err   = '0;
    m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".dout"},       dout,       m_dout);
    check_eq({tag, ".err_out"},    err_out,    m_err);
    check_eq({tag, ".dout_valid"}, dout_valid, m_valid);
    check_eq({tag, ".count"},      count,      m_q.size());
    check_eq({tag, ".empty"},      empty,      m_q.size() == 0);
    check_eq({tag, ".full"},       full,       m_q.size() == DEPTH);
    check_eq({tag, ".overrun"},    overrun,    m_ovr);
  endtask

  // Called 1 time unit after a rising edge; applies inputs for one cycle,
  // advances the model, then compares after the next rising edge.
  task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d,
                       input logic [EW-1:0] e, input logic r, input logic c);
    bit was_full, was_empty, racc, wacc, drop;
    logic [DW+EW-1:0] ent;
    wr_en   = w;
    din     = d;
    err_in  = e;
    rd_en   = r;
    ovr_clr = c;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    racc = r && !was_empty;
    wacc = w && (!was_full || r);
    drop = w && was_full && !r;
    m_valid = racc;
    if (racc) begin
      ent    = m_q.pop_front();
      m_dout = ent[DW+EW-1:EW];
      m_err  = ent[EW-1:0];
    end
    if (wacc) begin
      m_q.push_back({d, e[2:1], e[0] | m_pend});
      m_pend = 1'b0;
    end
    if (drop) begin
      m_pend = 1'b1;
      m_ovr  = 1'b1;
    end else if (c) begin
      m_ovr = 1'b0;
    end
    @(posedge clk_rx);
    #1;
    if (dout_valid === 1'b1) valid_pulses++;
    check_all(tag);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovr_clr = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    din     = '0;
    err_in  = '0;
    rd_en   = 1'b0;
    ovr_clr = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    #9 reset = 1'b0;
    @(posedge clk_rx);
    #1;

    // Three writes, three reads
    cycle("t1w", 1, 8'h41, 3'b000, 0, 0);
    cycle("t1w", 1, 8'h42, 3'b000, 0, 0);
    cycle("t1w", 1, 8'h43, 3'b000, 0, 0);
    valid_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cycle("t1r", 0, 8'h00, 3'b000, 1, 0);
      check_eq("t1.data", dout, 8'h41 + i);
    end
    cycle("t1idle", 0, 8'h00, 3'b000, 0, 0);
    check_eq("t1.pulses", valid_pulses, 3);

    // Fill, drop, write-with-read, drain
    for (int i = 0; i < DEPTH; i++) cycle("t2fill", 1, 8'(i), 3'b000, 0, 0);
    check_eq("t2.full", full, 1);
    cycle("t2drop", 1, 8'hAA, 3'b000, 0, 0);
    check_eq("t2.ovr", overrun, 1);
    cycle("t2wr", 1, 8'hBB, 3'b000, 1, 0);
    check_eq("t2.first_err", err_out, 3'b000);
    for (int i = 0; i < DEPTH; i++) cycle("t2drain", 0, 8'h00, 3'b000, 1, 0);
    check_eq("t2.bb_data", dout, 8'hBB);
    check_eq("t2.bb_err", err_out, 3'b001);
    cycle("t2clr", 0, 8'h00, 3'b000, 0, 1);

    // Error bits preserved, read on empty ignored
    cycle("t3w", 1, 8'h55, 3'b110, 0, 0);
    cycle("t3r", 0, 8'h00, 3'b000, 1, 0);
    check_eq("t3.err", err_out, 3'b110);
    cycle("t3re", 0, 8'h00, 3'b000, 1, 0);
    check_eq("t3.hold", dout, 8'h55);

    // Simultaneous wr/rd on empty
    cycle("t4wr", 1, 8'h7E, 3'b000, 1, 0);
    check_eq("t4.count", count, 1);
    cycle("t4r", 0, 8'h00, 3'b000, 1, 0);
    check_eq("t4.data", dout, 8'h7E);

    // Full FIFO, sustained wr/rd across pointer wrap, then clr vs drop
    for (int i = 0; i < DEPTH; i++) cycle("t5fill", 1, 8'(8'h80 + i), 3'b000, 0, 0);
    for (int i = 0; i < 20; i++) cycle("t5wr", 1, 8'($urandom), 3'($urandom), 1, 0);
    check_eq("t5.count", count, DEPTH);
    check_eq("t5.ovr0", overrun, 0);
    cycle("t5drop", 1, 8'h11, 3'b000, 0, 0);
    cycle("t5clrdrop", 1, 8'h22, 3'b000, 0, 1);
    check_eq("t5.ovr_set_wins", overrun, 1);
    cycle("t5clr", 0, 8'h00, 3'b000, 0, 1);
    check_eq("t5.ovr_cleared", overrun, 0);

    // Async reset mid-stream at count 9
    while (m_q.size() > 10) cycle("t6drain", 0, 8'h00, 3'b000, 1, 0);
    cycle("t6r", 0, 8'h00, 3'b000, 1, 0);
    check_eq("t6.count9", count, 9);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("t6async");
    #2 reset = 1'b0;
    @(posedge clk_rx);
    #1;
    cycle("t6w", 1, 8'hC3, 3'b010, 0, 0);
    cycle("t6r", 0, 8'h00, 3'b000, 1, 0);
    check_eq("t6.data", dout, 8'hC3);
    check_eq("t6.err", err_out, 3'b010);

    // Randomized traffic with varying read/write pressure
    for (int blk = 0; blk < 8; blk++) begin
      int unsigned pw = $urandom_range(20, 90);
      int unsigned pr = $urandom_range(20, 90);
      for (int i = 0; i < 100; i++) begin
        cycle("rand",
              $urandom_range(0, 99) < pw,
              8'($urandom),
              3'($urandom),
              $urandom_range(0, 99) < pr,
              $urandom_range(0, 99) < 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
